// File: rtl/usb_clock_report_pkg.sv
// Shared types for the clock-to-USB report path: token PIDs, BCD digits, report layout.
// The status byte layout is kept here so host-side decoders and the RTL agree on bit positions.
package usb_clock_report_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;

  typedef logic [0:0] rpt_state_t;
  localparam rpt_state_t IDLE = 1'b0;
  localparam rpt_state_t SEND = 1'b1;

  localparam int RPT_BYTES  = 8;
  localparam int RPT_IDX_W  = 3;
  localparam int STAT_SYNC  = 7;
  localparam int STAT_ERROR = 6;
  localparam int STAT_STALE = 5;

  function automatic logic [7:0] status_byte(input logic sync, input logic error, input logic stale);
    logic [7:0] s;
    s             = '0;
    s[STAT_SYNC]  = sync;
    s[STAT_ERROR] = error;
    s[STAT_STALE] = stale;
    return s;
  endfunction

endpackage

// File: rtl/usb_clock_report_if.sv
// Token strobe from usb_controller plus the report byte stream back to it.
// master = usb_controller side, slave = report generator side.
interface usb_clock_report_if;
  usb_clock_report_pkg::pid_t pid;
  logic                       token_valid;
  logic [6:0]                 address;
  logic [3:0]                 end_point;
  logic [7:0]                 out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;
  logic                       out_nak;

  modport master (
    output pid, token_valid, address, end_point, out_ready,
    input  out_data, out_valid, out_last, out_nak
  );

  modport slave (
    input  pid, token_valid, address, end_point, out_ready,
    output out_data, out_valid, out_last, out_nak
  );
endinterface

// File: rtl/usb_clock_report.sv
// Serves IN tokens with an 8-byte BCD time snapshot (first byte 1 cycle after the token) or a NAK.
// Bytes advance only on out_valid & out_ready; any token during a packet aborts it.
module usb_clock_report
  import usb_clock_report_pkg::*;
#(
  parameter logic [3:0] END_POINT      = 4'd1,
  parameter bit         NAK_WHEN_STALE = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          dev_address,
  usb_clock_report_if.slave   usb,
  input  bcd_t [1:0]          year,
  input  bcd_t [1:0]          month,
  input  bcd_t [1:0]          day,
  input  bcd_t [1:0]          hour,
  input  bcd_t [1:0]          minute,
  input  bcd_t [1:0]          second,
  input  logic [2:0]          day_of_week,
  input  logic                dcf77_sync,
  input  logic                dcf77_error
);

  rpt_state_t                   state;
  logic [RPT_IDX_W-1:0]         idx;
  logic [RPT_BYTES-1:0][7:0]    snapshot;
  logic [7:0]                   sec_prev;
  logic                         fresh;
  logic                         nak_q;
  logic                         match;
  logic                         accept;
  logic                         last_accept;
  logic                         new_second;

  assign match       = usb.token_valid && (usb.pid == PID_IN) &&
                       (usb.address == dev_address) && (usb.end_point == END_POINT);
  assign accept      = (state == SEND) && usb.out_ready;
  assign last_accept = accept && !usb.token_valid && (idx == RPT_IDX_W'(RPT_BYTES - 1));
  assign new_second  = (second != sec_prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      snapshot <= '0;
      fresh    <= 1'b0;
      nak_q    <= 1'b0;
      // Track the live second through reset so release alone never looks like a tick.
      sec_prev <= second;
    end else begin
      sec_prev <= second;
      nak_q    <= 1'b0;
      if (new_second) begin
        fresh <= 1'b1;
      end else if (last_accept) begin
        fresh <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (match) begin
            if (fresh || !NAK_WHEN_STALE) begin
              snapshot <= {second, minute, hour, {5'b0, day_of_week}, day, month, year,
                           status_byte(dcf77_sync, dcf77_error, !fresh)};
              idx      <= '0;
              state    <= SEND;
            end else begin
              nak_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (usb.token_valid) begin
            state <= IDLE;
          end else if (accept) begin
            idx <= idx + RPT_IDX_W'(1);
            if (last_accept) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign usb.out_valid = (state == SEND);
  assign usb.out_data  = (state == SEND) ? snapshot[idx] : 8'h00;
  assign usb.out_last  = (state == SEND) && (idx == RPT_IDX_W'(RPT_BYTES - 1));
  assign usb.out_nak   = nak_q;

endmodule
